ofifo_col_align: RTL and testbench
==================================

Name: ofifo_col_align

Overview:
- Output-alignment FIFO between the systolic array's bottom row of PEs and the output SRAM write path (128-bit words, 9-bit address).
- The array emits per-column partial sums skewed in time: column c becomes valid c cycles after column 0.
- The block buffers each column independently and presents one aligned 128-bit row once every column holds data.
- The core's writeback logic pops the aligned row and writes it to the output SRAM.

Parameters:
COL, 8, number of array columns (one independent FIFO lane per column)
PSUM_BW, 16, partial-sum width per column in bits
DEPTH, 64, entries per column lane; must be a power of 2, minimum 2

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous active-low reset (0 = reset asserted)
wr  input  COL  per-column push strobe; bit c pushes lane c
in  input  COL*PSUM_BW  column data; lane c = bits [c*PSUM_BW +: PSUM_BW], column 0 at LSB
rd  input  1  pop one aligned row from all lanes
out  output  COL*PSUM_BW  aligned row (head of each lane), same lane packing as in
o_valid  output  1  every lane non-empty; out holds a complete row
o_full  output  1  at least one lane full
o_ready  output  1  no lane full (equals ~o_full)
o_ovf  output  1  sticky overflow/underflow error flag

Behaviour:
- Reset (reset=0, asynchronous):
  - All read/write pointers and per-lane counts clear immediately.
  - o_valid=0, o_full=0, o_ready=1, o_ovf=0, out=0.
  - Storage contents are not reset.
  - Reset mid-operation discards all buffered data; no partial pop occurs.
- Lane storage:
  - Circular buffer per lane with log2(DEPTH) pointers that wrap modulo DEPTH.
  - Per-lane count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Push, lane c:
  - On a clk edge with wr[c]=1 and lane c not full: store in slice c at wr_ptr[c], then increment wr_ptr[c].
  - Lanes push independently; any subset of wr may be set in one cycle.
- Pop (all lanes together):
  - On a clk edge with rd=1 and o_valid=1: increment every rd_ptr.
  - A pop is all-or-nothing across lanes.
- Output timing:
  - First-word-fall-through. out is combinational from lane heads, gated to 0 when o_valid=0.
  - Latency: a word written at edge N is visible at out after edge N, once all lanes are non-empty.
  - Zero-bubble: a row completed at edge N can be popped at edge N+1.
- Simultaneous push and pop on the same lane:
  - Both take effect; the lane count is unchanged.
  - A full lane with wr[c]=1 and an accepted pop in the same cycle accepts the push, since the pop frees a slot.
- Overflow: wr[c]=1 on a full lane without a same-cycle pop drops the data, leaves pointers unchanged and sets o_ovf.
- Underflow: rd=1 with o_valid=0 is ignored and sets o_ovf.
- o_ovf clears only on reset.
- Flags:
  - o_valid, o_full and o_ready are derived from registered counts.
  - They update in the cycle after the causing edge and are glitch-free relative to clk.
- Data is passed through unmodified; the block performs no arithmetic or sign handling.

Test Plan:
1. Skewed fill: wr[c] asserted at cycle t0+c for c=0..7, lane c data = 16'h1000+c -> o_valid rises only after lane 7 is written; out = {16'h1007,...,16'h1000}; rd pops it and o_valid falls.
2. Streaming: 16 rows pushed with skew, each row value r*16+c, rd held high whenever o_valid -> 16 rows out in order, no gaps after the first, o_ovf=0 (mirrors the 16-word output SRAM load).
3. Full/wrap: fill lane 0 with 64 words while lanes 1..7 stay empty -> o_full=1, o_ready=0; 65th push dropped and o_ovf=1. Fill the other lanes, pop 64 rows, refill past the wrap -> order preserved.
4. Simultaneous: with all lanes full, rd=1 and wr=8'hFF with new data 16'hBEEF -> accepted, counts stay 64, o_ovf stays 0, and 16'hBEEF emerges 64 pops later.
5. Underflow: rd=1 while lane 3 is empty -> no pointer moves, other lanes' data intact, o_ovf=1, out=0.
6. Async reset: assert reset=0 mid-stream between clock edges -> outputs reach reset values without a clock edge; after release, o_valid=0 and a fresh skewed row is read back correctly.

Source files
------------

// File: rtl/ofifo_col_align.sv
// Output-alignment FIFO: one independent circular lane per array column, with
// a single first-word-fall-through read port that presents a row only once every lane holds data.
module ofifo_col_align #(
  parameter int unsigned COL     = 8,
  parameter int unsigned PSUM_BW = 16,
  parameter int unsigned DEPTH   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COL-1:0]         wr,
  input  logic [COL*PSUM_BW-1:0] in,
  input  logic                   rd,
  output logic [COL*PSUM_BW-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  logic [PSUM_BW-1:0] mem [COL][DEPTH];
  ptr_t               wr_ptr [COL];
  ptr_t               rd_ptr [COL];
  cnt_t               cnt    [COL];

  logic [COL-1:0] lane_empty;
  logic [COL-1:0] lane_full;
  logic [COL-1:0] push;
  logic           pop;
  logic           ovf_evt;

  always_comb begin
    lane_empty = '0;
    lane_full  = '0;
    for (int unsigned c = 0; c < COL; c++) begin
      lane_empty[c] = (cnt[c] == '0);
      lane_full[c]  = (cnt[c] == cnt_t'(DEPTH));
    end
  end

  assign o_valid = ~|lane_empty;
  assign o_full  = |lane_full;
  assign o_ready = ~o_full;
  assign pop     = rd & o_valid;

  // A pop in the same cycle frees a slot, so a full lane may still accept a push.
  always_comb begin
    push = '0;
    for (int unsigned c = 0; c < COL; c++) begin
      push[c] = wr[c] & (~lane_full[c] | pop);
    end
  end

  assign ovf_evt = (|(wr & ~push)) | (rd & ~o_valid);

  always_comb begin
    out = '0;
    if (o_valid) begin
      for (int unsigned c = 0; c < COL; c++) begin
        out[c*PSUM_BW +: PSUM_BW] = mem[c][rd_ptr[c]];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < COL; c++) begin
      if (push[c]) begin
        mem[c][wr_ptr[c]] <= in[c*PSUM_BW +: PSUM_BW];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < COL; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        cnt[c]    <= '0;
      end
      o_ovf <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < COL; c++) begin
        if (push[c]) begin
          wr_ptr[c] <= ptr_t'(wr_ptr[c] + 1'b1);
        end
        if (pop) begin
          rd_ptr[c] <= ptr_t'(rd_ptr[c] + 1'b1);
        end
        if (push[c] && !pop) begin
          cnt[c] <= cnt_t'(cnt[c] + 1'b1);
        end else if (pop && !push[c]) begin
          cnt[c] <= cnt_t'(cnt[c] - 1'b1);
        end
      end
      if (ovf_evt) begin
        o_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ofifo_col_align.sv
// Bench for ofifo_col_align: per-lane reference queues hold the words expected
// to emerge from the DUT; rows are compared against the queue heads every cycle.
module tb_ofifo_col_align;

  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 64;
  localparam int RW    = COL * BW;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic [COL-1:0] wr   = '0;
  logic [RW-1:0]  in   = '0;
  logic           rd   = 1'b0;
  logic [RW-1:0]  out;
  logic           o_valid;
  logic           o_full;
  logic           o_ready;
  logic           o_ovf;

  ofifo_col_align #(.COL(COL), .PSUM_BW(BW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr(wr), .in(in), .rd(rd),
    .out(out), .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [BW-1:0] lq [COL][$];
  logic m_ovf = 1'b0;
  int rows_popped = 0;
  int cyc = 0;
  int first_pop = -1;
  int last_pop  = -1;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic m_valid();
    for (int c = 0; c < COL; c++) if (lq[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_full();
    for (int c = 0; c < COL; c++) if (lq[c].size() == DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [RW-1:0] m_head();
    logic [RW-1:0] r = '0;
    if (m_valid()) for (int c = 0; c < COL; c++) r[c*BW +: BW] = lq[c][0];
    return r;
  endfunction

  task automatic check_state();
    check("valid", 128'(o_valid), 128'(m_valid()));
    check("full",  128'(o_full),  128'(m_full()));
    check("ready", 128'(o_ready), 128'(!m_full()));
    check("ovf",   128'(o_ovf),   128'(m_ovf));
    check("out",   128'(out),     128'(m_head()));
  endtask

  // Called just after a falling edge: check, drive, update the model, advance one clock.
  task automatic cycle(input logic [COL-1:0] w, input logic [RW-1:0] d, input logic r);
    logic pop;
    logic [COL-1:0] acc;
    check_state();
    wr = w; in = d; rd = r;
    pop = r && m_valid();
    if (r && !pop) m_ovf = 1'b1;
    for (int c = 0; c < COL; c++) begin
      acc[c] = w[c] && (lq[c].size() < DEPTH || pop);
      if (w[c] && !acc[c]) m_ovf = 1'b1;
    end
    if (pop) begin
      rows_popped++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      for (int c = 0; c < COL; c++) void'(lq[c].pop_front());
    end
    for (int c = 0; c < COL; c++) if (acc[c]) lq[c].push_back(d[c*BW +: BW]);
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asserts reset between clock edges and checks outputs before any edge arrives.
  task automatic do_reset();
    wr = '0; rd = 1'b0;
    #1 reset = 1'b0;
    #1;
    for (int c = 0; c < COL; c++) lq[c].delete();
    m_ovf = 1'b0;
    check_state();
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [RW-1:0] fill_row(input int base);
    logic [RW-1:0] r;
    for (int c = 0; c < COL; c++) r[c*BW +: BW] = 16'(base + c);
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RW-1:0] d;
    logic [COL-1:0] w;

    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_state();
    reset = 1'b1;

    // Skewed fill, lane c written on cycle c.
    for (int c = 0; c < COL; c++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      d[c*BW +: BW] = 16'(16'h1000 + c);
      cycle(COL'(1) << c, d, 1'b0);
    end
    check("t1_row", 128'(out), 128'(fill_row(16'h1000)));
    check("t1_valid", 128'(o_valid), 128'd1);
    cycle('0, '0, 1'b1);
    cycle('0, '0, 1'b0);

    // Streaming 16 skewed rows with rd following o_valid.
    rows_popped = 0; first_pop = -1; last_pop = -1;
    for (int t = 0; t < 40; t++) begin
      w = '0; d = '0;
      for (int c = 0; c < COL; c++) begin
        if (t - c >= 0 && t - c < 16) begin
          w[c] = 1'b1;
          d[c*BW +: BW] = 16'((t - c) * 16 + c);
        end
      end
      cycle(w, d, o_valid);
    end
    check("t2_rows", 128'(rows_popped), 128'd16);
    check("t2_gapless", 128'(last_pop - first_pop), 128'd15);
    check("t2_ovf", 128'(o_ovf), 128'd0);

    // All lanes full, then simultaneous push+pop of BEEF.
    for (int i = 0; i < DEPTH; i++) cycle('1, fill_row(16'h4000 + i * 8), 1'b0);
    check("t4_full", 128'(o_full), 128'd1);
    cycle('1, {COL{16'hBEEF}}, 1'b1);
    check("t4_still_full", 128'(o_full), 128'd1);
    check("t4_ovf", 128'(o_ovf), 128'd0);
    for (int i = 0; i < DEPTH - 1; i++) cycle('0, '0, 1'b1);
    check("t4_beef", 128'(out), 128'({COL{16'hBEEF}}));
    cycle('0, '0, 1'b1);

    // Lane 0 alone to full, overflow, then fill others, pop, refill past wrap.
    for (int i = 0; i < DEPTH; i++) cycle(8'h01, fill_row(16'h3000 + i), 1'b0);
    check("t3_full", 128'(o_full), 128'd1);
    check("t3_ready", 128'(o_ready), 128'd0);
    cycle(8'h01, {COL{16'hDEAD}}, 1'b0);
    check("t3_ovf", 128'(o_ovf), 128'd1);
    for (int i = 0; i < DEPTH; i++) cycle(8'hFE, fill_row(16'h3000 + i), 1'b0);
    for (int i = 0; i < 32; i++) cycle('0, '0, 1'b1);
    for (int i = 0; i < 32; i++) cycle('1, fill_row(16'h5000 + i * 8), 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle('0, '0, 1'b1);
    cycle('0, '0, 1'b0);

    // Async reset in the middle of a stream, then a fresh skewed row.
    for (int i = 0; i < 5; i++) cycle('1, fill_row(16'h2000 + i * 8), i > 2);
    do_reset();
    for (int c = 0; c < COL; c++) begin
      d = '0;
      d[c*BW +: BW] = 16'(16'h6000 + c);
      cycle(COL'(1) << c, d, 1'b0);
    end
    check("t6_row", 128'(out), 128'(fill_row(16'h6000)));
    cycle('0, '0, 1'b1);
    cycle('0, '0, 1'b0);

    // Underflow with lane 3 empty.
    do_reset();
    cycle(8'hF7, fill_row(16'h7000), 1'b0);
    cycle('0, '0, 1'b1);
    check("t5_ovf", 128'(o_ovf), 128'd1);
    check("t5_out0", 128'(out), 128'd0);
    cycle(8'h08, fill_row(16'h7000), 1'b0);
    check("t5_row", 128'(out), 128'(fill_row(16'h7000)));
    cycle('0, '0, 1'b1);
    cycle('0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
